logic_op_arbiter: RTL



---
 rtl/logic_op_pkg.sv | 13 +
 rtl/logic_unit.sv | 27 ++
 rtl/logic_op_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// Opcode encodings and widths shared by the logic-op arbiter and its datapath.
package logic_op_pkg;
    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_NOT  = 3'd2;
    localparam logic [OPW-1:0] OP_NAND = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [OPW-1:0] OP_XOR  = 3'd5;
    localparam logic [OPW-1:0] OP_XNOR = 3'd6;
    localparam logic [OPW-1:0] OP_RSVD = 3'd7;
endpackage

// File: rtl/logic_unit.sv
// Combinational W-bit bitwise logic unit; reserved opcode yields zero with err set.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y,
    output logic           err
);
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters, with a
// single-entry tagged result register. Define LOGIC_OP_ARBITER_STATS_EN for op_count.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W-1:0]        res_data,
    output logic [IDW-1:0]      res_id,
    output logic                res_err
`ifdef LOGIC_OP_ARBITER_STATS_EN
    ,
    output logic [15:0]         op_count
`endif
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           res_err_q, res_err_d;

    logic           can_accept;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           xfer;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_a, sel_b;
    logic [W-1:0]   lu_y;
    logic           lu_err;

    assign can_accept = !res_valid_q || res_ready;

    // Scan from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IDW-1:0];
            end
        end
    end

    // Gated by rst so ready drops the instant reset asserts.
    always_comb begin
        req_ready = '0;
        if (grant_found && can_accept && !rst)
            req_ready[grant_idx] = 1'b1;
    end

    assign xfer   = |(req_valid & req_ready);
    assign sel_op = req_op[grant_idx*OPW +: OPW];
    assign sel_a  = req_a[grant_idx*W +: W];
    assign sel_b  = req_b[grant_idx*W +: W];

    logic_unit #(.W(W)) u_logic_unit (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (lu_y),
        .err (lu_err)
    );

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_data_d  = lu_y;
            res_id_d    = grant_idx;
            res_err_d   = lu_err;
            ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;

`ifdef LOGIC_OP_ARBITER_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (xfer && op_count_q != 16'hFFFF)
            op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_count_q <= '0;
        else     op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif
endmodule
